// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - pipeline and bus signal bundle for mem_access_ctrl
interface mem_access_ctrl_if;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        bus_err_o;
  logic        misalign_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  // Controller side
  modport slave (
    input  mem_rd_i, mem_wr_i, funct3_i, addr_i, wdata_i, bus_ack_i, bus_rdata_i,
    output stall_o, done_o, rdata_o, bus_err_o, misalign_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
  );

  // Pipeline plus bus-responder side
  modport master (
    output mem_rd_i, mem_wr_i, funct3_i, addr_i, wdata_i, bus_ack_i, bus_rdata_i,
    input  stall_o, done_o, rdata_o, bus_err_o, misalign_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store bus access controller with timeout; optional trap via MEM_MISALIGN_TRAP_EN
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic            clk_i,
  input logic            rst_i,
  mem_access_ctrl_if.slave m
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_t      state;
  logic [9:0]  cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        we_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        done_q;
  logic        err_q;
  logic        mis_q;
  logic [31:0] rdata_q;

  logic        new_req;
  logic        misalign_req;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  assign new_req = m.mem_rd_i | m.mem_wr_i;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_req = ((m.funct3_i[1:0] == 2'b01) && m.addr_i[0]) ||
                        ((m.funct3_i == 3'b010) && (m.addr_i[1:0] != 2'b00));
`else
  assign misalign_req = 1'b0;
`endif

  // Lane placement of store data and byte enables from the incoming request
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = m.wdata_i;
    case (m.funct3_i[1:0])
      2'b00: begin
        be_next    = 4'b0001 << m.addr_i[1:0];
        wdata_next = {4{m.wdata_i[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {m.addr_i[1], 1'b0};
        wdata_next = {2{m.wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension using the latched size and low address bits
  always_comb begin
    case (addr_lo_q)
      2'b00:   byte_lane = m.bus_rdata_i[7:0];
      2'b01:   byte_lane = m.bus_rdata_i[15:8];
      2'b10:   byte_lane = m.bus_rdata_i[23:16];
      default: byte_lane = m.bus_rdata_i[31:24];
    endcase
    half_lane = addr_lo_q[1] ? m.bus_rdata_i[31:16] : m.bus_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'd0, byte_lane};
      3'b101:  load_ext = {16'd0, half_lane};
      default: load_ext = m.bus_rdata_i;
    endcase
  end

  // Access FSM: accept in IDLE, hold the bus in REQ until ack or timeout, pulse in DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      we_q      <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      mis_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (new_req) begin
            funct3_q  <= m.funct3_i;
            addr_lo_q <= m.addr_i[1:0];
            if (misalign_req) begin
              state   <= DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state   <= REQ;
              cnt     <= '0;
              req_q   <= 1'b1;
              we_q    <= m.mem_wr_i;
              addr_q  <= {m.addr_i[31:2], 2'b00};
              wdata_q <= wdata_next;
              be_q    <= be_next;
            end
          end
        end
        REQ: begin
          if (m.bus_ack_i || (cnt == TO_LAST)) begin
            state   <= DONE;
            done_q  <= 1'b1;
            err_q   <= ~m.bus_ack_i;
            rdata_q <= (m.bus_ack_i && !we_q) ? load_ext : 32'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m.stall_o     = ~rst_i & (((state == IDLE) & new_req) | (state == REQ));
  assign m.done_o      = done_q;
  assign m.rdata_o     = rdata_q;
  assign m.bus_err_o   = err_q;
  assign m.misalign_o  = mis_q;
  assign m.bus_req_o   = req_q;
  assign m.bus_we_o    = we_q;
  assign m.bus_addr_o  = addr_q;
  assign m.bus_wdata_o = wdata_q;
  assign m.bus_be_o    = be_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_access_ctrl_if m ();

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .m     (m)
  );

  always #5 clk = ~clk;

  // Reference model: byte enables from size and byte offset
  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned a = addr % 4;
    if (f3 % 4 == 0) return 4'(1 << a);
    if (f3 % 4 == 1) return 4'(3 << (2 * (a / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (f3 % 4 == 0) return (w % 256) * 32'h0101_0101;
    if (f3 % 4 == 1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    int unsigned a = addr % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (rd >> (8 * a)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (rd >> (16 * (a / 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // One full access with ack after 'delay' wait cycles; checks every cycle
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdat, input int delay, input string nm);
    logic [71:0] got, want;
    logic [31:0] exp_rd;
    m.mem_rd_i = rd; m.mem_wr_i = wr; m.funct3_i = f3; m.addr_i = addr; m.wdata_i = wd;
    @(negedge clk);
    n_checks++;
    if (m.stall_o !== 1'b1) begin n_fail++; $display("FAIL %s idle_stall got=%b want=1", nm, m.stall_o); end
    @(posedge clk); #1;
    m.mem_rd_i = 1'b0; m.mem_wr_i = 1'b0; m.addr_i = $urandom; m.wdata_i = $urandom;
    want = {1'b1, wr, addr & 32'hFFFF_FFFC, exp_be(f3, addr), exp_wdata(f3, wd), 1'b1, 1'b0};
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      got = {m.bus_req_o, m.bus_we_o, m.bus_addr_o, m.bus_be_o, m.bus_wdata_o, m.stall_o, m.done_o};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL %s req_cycle%0d got=%h want=%h", nm, i, got, want); end
      if (i == delay) begin m.bus_ack_i = 1'b1; m.bus_rdata_i = rdat; end
      @(posedge clk); #1;
      m.bus_ack_i = 1'b0; m.bus_rdata_i = $urandom;
    end
    exp_rd = wr ? 32'd0 : exp_load(f3, addr, rdat);
    @(negedge clk);
    n_checks++;
    if ({m.done_o, m.bus_req_o, m.stall_o, m.bus_err_o, m.misalign_o} !== 5'b10000) begin
      n_fail++; $display("FAIL %s done_flags got=%b want=10000", nm, {m.done_o, m.bus_req_o, m.stall_o, m.bus_err_o, m.misalign_o});
    end
    n_checks++;
    if (m.rdata_o !== exp_rd) begin n_fail++; $display("FAIL %s rdata got=%h want=%h", nm, m.rdata_o, exp_rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    m.mem_rd_i = 1'b1; m.mem_wr_i = 1'b0; m.funct3_i = 3'b010; m.addr_i = 32'h40;
    m.wdata_i = 32'h0; m.bus_ack_i = 1'b0; m.bus_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({m.stall_o, m.done_o, m.bus_err_o, m.misalign_o, m.bus_req_o, m.bus_we_o, m.bus_be_o,
         m.bus_addr_o, m.bus_wdata_o, m.rdata_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=nonzero stall=%b req=%b rdata=%h want=all0", m.stall_o, m.bus_req_o, m.rdata_o);
    end
    m.mem_rd_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_store_byte();
    do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, "sb_103");
  endtask

  task automatic test_load_sign();
    do_access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080_0000, 0, "lb_102");
    do_access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080_0000, 1, "lbu_102");
    do_access(1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 32'h8001_7FFF, 2, "lh_2");
  endtask

  task automatic test_timeout();
    int cycles = 0;
    m.mem_rd_i = 1'b1; m.funct3_i = 3'b010; m.addr_i = 32'h200;
    @(posedge clk); #1;
    m.mem_rd_i = 1'b0;
    @(negedge clk);
    while (m.bus_req_o === 1'b1 && cycles < 20) begin cycles++; @(negedge clk); end
    n_checks++;
    if (cycles != 4) begin n_fail++; $display("FAIL timeout_req_cycles got=%0d want=4", cycles); end
    n_checks++;
    if ({m.done_o, m.bus_err_o, m.stall_o, m.rdata_o} !== {3'b110, 32'd0}) begin
      n_fail++; $display("FAIL timeout_done got=%b%b%b %h want=110 00000000", m.done_o, m.bus_err_o, m.stall_o, m.rdata_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_req();
    m.mem_rd_i = 1'b1; m.funct3_i = 3'b010; m.addr_i = 32'h300;
    @(posedge clk); #1;
    m.mem_rd_i = 1'b0;
    n_checks++;
    if (m.bus_req_o !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_req got=%b want=1", m.bus_req_o); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({m.bus_req_o, m.stall_o, m.done_o} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_async got=%b want=000", {m.bus_req_o, m.stall_o, m.done_o});
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({m.bus_req_o, m.stall_o} !== 2'b00) begin n_fail++; $display("FAIL midrst_idle got=%b want=00", {m.bus_req_o, m.stall_o}); end
    do_access(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'hDEAD_BEEF, 0, "lw_after_rst");
  endtask

  task automatic test_ack_ignored();
    m.bus_ack_i = 1'b1; m.bus_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    m.bus_ack_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m.done_o, m.bus_err_o, m.bus_req_o} !== 3'b000) begin
      n_fail++; $display("FAIL idle_ack got=%b want=000", {m.done_o, m.bus_err_o, m.bus_req_o});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    m.mem_rd_i = 1'b1; m.funct3_i = 3'b010; m.addr_i = 32'h102;
    @(posedge clk); #1;
    m.mem_rd_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m.bus_req_o, m.misalign_o, m.done_o, m.rdata_o} !== {3'b011, 32'd0}) begin
      n_fail++; $display("FAIL misalign_trap got=%b%b%b %h want=011 00000000", m.bus_req_o, m.misalign_o, m.done_o, m.rdata_o);
    end
    @(posedge clk); #1;
`else
    do_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 0, "lw_misaligned");
    do_access(1'b0, 1'b1, 3'b001, 32'h3, 32'h0000_BEEF, 32'h0, 1, "sh_misaligned");
`endif
  endtask

  task automatic test_both_high();
    do_access(1'b1, 1'b1, 3'b010, 32'h80, 32'h1357_9BDF, 32'h0, 1, "rd_wr_both");
  endtask

  task automatic test_random();
    logic [2:0]  codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          rd, wr;
    for (int i = 0; i < 40; i++) begin
      f3   = codes[$urandom_range(0, 4)];
      wr   = 1'($urandom_range(0, 1));
      rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr && f3[2]) f3[2] = 1'b0;
      addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      if (f3[1:0] == 2'b01) addr[0] = 1'b0;
      if (f3 == 3'b010) addr[1:0] = 2'b00;
`endif
      do_access(rd, wr, f3, addr, $urandom, $urandom, $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_sign();
    test_timeout();
    test_reset_mid_req();
    test_ack_ignored();
    test_misalign();
    test_both_high();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
